// File: rtl/wordle_guess_scorer.sv
// Scores one 5-letter guess against the target word in two passes (green, then yellow)
// and emits one colour write per tile. Optional macro: DUP_LETTER_EN (consuming yellow rule).
module wordle_guess_scorer #(
  parameter int LETTER_W = 8,
  parameter int WORD_LEN = 5,
  parameter int NUM_ROWS = 6
) (
  input  logic                         board_clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WORD_LEN*LETTER_W-1:0] guess,
  input  logic [WORD_LEN*LETTER_W-1:0] target,
  input  logic [2:0]                   row_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         win,
  output logic                         wr_en,
  output logic [2:0]                   wr_row,
  output logic [2:0]                   wr_col,
  output logic [2:0]                   wr_color
);

  localparam logic [2:0] LAST_COL  = 3'(WORD_LEN - 1);
  localparam logic [2:0] C_GREEN   = 3'b010;
  localparam logic [2:0] C_YELLOW  = 3'b110;
  localparam logic [2:0] C_MISS    = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_DONE} state_t;

  state_t                       r_state;
  logic [2:0]                   r_col;
  logic [WORD_LEN*LETTER_W-1:0] r_guess, r_target;
  logic [WORD_LEN-1:0]          r_green;
  logic                         r_busy, r_done, r_err, r_win, r_wr_en;
  logic [2:0]                   r_wr_row, r_wr_col, r_wr_color;
`ifdef DUP_LETTER_EN
  logic [WORD_LEN-1:0]          r_used;
  logic [WORD_LEN-1:0]          w_used_base, w_hit_vec;
`endif
  logic [WORD_LEN-1:0]          w_green_upd, w_mask, w_used_next;
  logic [2:0]                   w_sel_col, w_color;
  logic [LETTER_W-1:0]          w_sel_letter;
  logic                         w_yel_hit;

  function automatic logic [LETTER_W-1:0] get_letter(
    input logic [WORD_LEN*LETTER_W-1:0] word, input logic [2:0] idx);
    return word[(WORD_LEN-1-int'(idx))*LETTER_W +: LETTER_W];
  endfunction

  // Next write is computed one cycle ahead so the colour outputs can stay registered;
  // the first yellow column is evaluated on the last green cycle with the final green mask.
  always_comb begin
    w_green_upd = r_green;
    w_green_upd[r_col] = (get_letter(r_guess, r_col) == get_letter(r_target, r_col));
    w_sel_col = (r_state == S_GREEN || r_col == LAST_COL) ? 3'd0 : r_col + 3'd1;
    w_mask = (r_state == S_GREEN) ? w_green_upd : r_green;
    w_sel_letter = get_letter(r_guess, w_sel_col);
    w_yel_hit = 1'b0;
    w_used_next = '0;
`ifdef DUP_LETTER_EN
    w_used_base = (r_state == S_GREEN) ? w_green_upd : r_used;
    w_hit_vec = '0;
    for (int j = WORD_LEN - 1; j >= 0; j--) begin
      if (!w_used_base[j] && !w_mask[j] && get_letter(r_target, 3'(j)) == w_sel_letter) begin
        w_yel_hit = 1'b1;
        w_hit_vec = '0;
        w_hit_vec[j] = 1'b1;
      end
    end
    w_used_next = w_used_base | (w_mask[w_sel_col] ? '0 : w_hit_vec);
`else
    for (int j = 0; j < WORD_LEN; j++)
      if (get_letter(r_target, 3'(j)) == w_sel_letter) w_yel_hit = 1'b1;
`endif
    w_color = w_mask[w_sel_col] ? C_GREEN : (w_yel_hit ? C_YELLOW : C_MISS);
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_guess    <= '0;
      r_target   <= '0;
      r_green    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_win      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_row   <= '0;
      r_wr_col   <= '0;
      r_wr_color <= '0;
`ifdef DUP_LETTER_EN
      r_used     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (int'(row_idx) < NUM_ROWS) begin
              r_guess  <= guess;
              r_target <= target;
              r_wr_row <= row_idx;
              r_green  <= '0;
`ifdef DUP_LETTER_EN
              r_used   <= '0;
`endif
              r_col    <= '0;
              r_busy   <= 1'b1;
              r_win    <= 1'b0;
              r_state  <= S_GREEN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_GREEN: begin
          r_green <= w_green_upd;
          if (r_col == LAST_COL) begin
            r_col      <= '0;
            r_wr_en    <= 1'b1;
            r_wr_col   <= 3'd0;
            r_wr_color <= w_color;
`ifdef DUP_LETTER_EN
            r_used     <= w_used_next;
`endif
            r_state    <= S_YELLOW;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
        S_YELLOW: begin
          if (r_col == LAST_COL) begin
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_win   <= &r_green;
            r_state <= S_DONE;
          end else begin
            r_col      <= r_col + 3'd1;
            r_wr_col   <= w_sel_col;
            r_wr_color <= w_color;
`ifdef DUP_LETTER_EN
            r_used     <= w_used_next;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign win      = r_win;
  assign wr_en    = r_wr_en;
  assign wr_row   = r_wr_row;
  assign wr_col   = r_wr_col;
  assign wr_color = r_wr_color;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Directed, table-driven bench for wordle_guess_scorer; expectations follow DUP_LETTER_EN.
module tb_wordle_guess_scorer;

  logic        board_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [39:0] guess = '0;
  logic [39:0] target = '0;
  logic [2:0]  row_idx = '0;
  logic        busy, done, err, win, wr_en;
  logic [2:0]  wr_row, wr_col, wr_color;

  int tests = 0;
  int fails = 0;

  wordle_guess_scorer dut (
    .board_clk(board_clk), .reset(reset), .start(start), .guess(guess), .target(target),
    .row_idx(row_idx), .busy(busy), .done(done), .err(err), .win(win), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .wr_color(wr_color)
  );

  always #5 board_clk = ~board_clk;

  typedef struct {
    logic [39:0] g;
    logic [39:0] t;
    logic [2:0]  row;
    logic [14:0] colors;
    logic        w;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // start is sampled on the edge ending cycle 0; loop index c is the cycle number
  task automatic run_vec(input vec_t v, input int extra_start);
    int writes;
    int dones;
    logic [14:0] cols;
    writes = 0;
    dones = 0;
    cols = v.colors;
    @(negedge board_clk);
    start = 1'b1; guess = v.g; target = v.t; row_idx = v.row;
    for (int c = 1; c <= 14; c++) begin
      @(negedge board_clk);
      start = (c == extra_start);
      if (c == 1) check("busy_c1", int'(busy), 1);
      if (c == 10) check("busy_c10", int'(busy), 1);
      if (wr_en) begin
        if (writes < 5) begin
          check("wr_cycle", c, 6 + writes);
          check("wr_col", int'(wr_col), writes);
          check("wr_row", int'(wr_row), int'(v.row));
          check("wr_color", int'(wr_color), int'(cols[14 - 3*writes -: 3]));
        end
        writes++;
      end
      if (done) begin
        check("done_cycle", c, 11);
        check("win", int'(win), int'(v.w));
        dones++;
      end
    end
    check("write_count", writes, 5);
    check("done_count", dones, 1);
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{g: "CRANE", t: "CRANE", row: 3'd0, colors: {3'b010, 3'b010, 3'b010, 3'b010, 3'b010}, w: 1'b1};
`ifdef DUP_LETTER_EN
    vecs[1] = '{g: "EERIE", t: "CRANE", row: 3'd1, colors: {3'b111, 3'b111, 3'b110, 3'b111, 3'b010}, w: 1'b0};
    vecs[2] = '{g: "BOBBY", t: "ABBEY", row: 3'd2, colors: {3'b110, 3'b111, 3'b010, 3'b111, 3'b010}, w: 1'b0};
`else
    vecs[1] = '{g: "EERIE", t: "CRANE", row: 3'd1, colors: {3'b110, 3'b110, 3'b110, 3'b111, 3'b010}, w: 1'b0};
    vecs[2] = '{g: "BOBBY", t: "ABBEY", row: 3'd2, colors: {3'b110, 3'b111, 3'b010, 3'b110, 3'b010}, w: 1'b0};
`endif
    vecs[3] = '{g: "crane", t: "CRANE", row: 3'd5, colors: {3'b111, 3'b111, 3'b111, 3'b111, 3'b111}, w: 1'b0};
    vecs[4] = '{g: "NACRE", t: "CRANE", row: 3'd3, colors: {3'b110, 3'b110, 3'b110, 3'b110, 3'b010}, w: 1'b0};

    repeat (3) @(negedge board_clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_win", int'(win), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_bus", int'({wr_row, wr_col, wr_color}), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], -1);

    // win held from a winning guess, then out-of-range rows must not disturb it
    run_vec(vecs[0], -1);
    for (int r = 6; r <= 7; r++) begin
      int wr_seen;
      wr_seen = 0;
      @(negedge board_clk);
      start = 1'b1; row_idx = 3'(r);
      @(negedge board_clk);
      start = 1'b0;
      check("err_pulse", int'(err), 1);
      check("err_busy", int'(busy), 0);
      for (int c = 0; c < 6; c++) begin
        @(negedge board_clk);
        if (c == 0) check("err_clear", int'(err), 0);
        if (wr_en || busy) wr_seen++;
      end
      check("err_no_activity", wr_seen, 0);
      check("err_win_held", int'(win), 1);
    end

    // second start mid-GREEN is ignored
    run_vec(vecs[2], 4);
    run_vec(vecs[0], 4);

    // reset mid-YELLOW aborts with no done and no further writes
    begin
      int stray;
      stray = 0;
      @(negedge board_clk);
      start = 1'b1; guess = "CRANE"; target = "CRANE"; row_idx = 3'd4;
      for (int c = 1; c <= 7; c++) begin
        @(negedge board_clk);
        start = 1'b0;
      end
      check("pre_rst_wr_en", int'(wr_en), 1);
      reset = 1'b1;
      #1;
      check("rst_mid_wr_en", int'(wr_en), 0);
      check("rst_mid_busy", int'(busy), 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge board_clk);
        if (done || wr_en) stray++;
      end
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge board_clk);
        if (done || wr_en || busy) stray++;
      end
      check("rst_mid_no_activity", stray, 0);
      run_vec(vecs[1], -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
